// File: rtl/bp_me_nonsynth_pkg.sv
// Shared types for the non-synthesizable ME monitors: bedrock request message types,
// the LCE request statistics FSM states and the header layout helpers.
package bp_me_nonsynth_pkg;

  localparam int unsigned MsgTypeWidth = 4;
  localparam int unsigned SubopWidth   = 4;
  localparam int unsigned SizeWidth    = 3;
  // addr sits directly above msg_type and subop
  localparam int unsigned AddrLsb      = MsgTypeWidth + SubopWidth;

  typedef enum logic [MsgTypeWidth-1:0] {
    e_bedrock_req_rd     = 4'd0,
    e_bedrock_req_wr     = 4'd1,
    e_bedrock_req_uc_rd  = 4'd2,
    e_bedrock_req_uc_wr  = 4'd3,
    e_bedrock_req_uc_amo = 4'd4
  } bp_bedrock_req_type_e;

  typedef enum logic [0:0] {
    e_stats_idle = 1'b0,
    e_stats_wait = 1'b1
  } bp_me_lce_stats_state_e;

  // Header layout (LSB first): msg_type, subop, addr, size, payload{cce_id, lce_id, way_id}
  function automatic int unsigned lce_req_header_width(input int unsigned paddr_width,
                                                       input int unsigned lce_id_width,
                                                       input int unsigned cce_id_width,
                                                       input int unsigned lce_assoc);
    return MsgTypeWidth + SubopWidth + paddr_width + SizeWidth
           + cce_id_width + lce_id_width + $clog2(lce_assoc);
  endfunction

  function automatic logic is_uc_req(input logic [MsgTypeWidth-1:0] msg_type);
    return (msg_type == e_bedrock_req_uc_rd) || (msg_type == e_bedrock_req_uc_wr);
  endfunction

endpackage

// File: rtl/bp_me_nonsynth_lat_accum.sv
// Latency accumulator: running minimum, maximum and saturating sum of recorded latencies.
module bp_me_nonsynth_lat_accum
  import bp_me_nonsynth_pkg::*;
#(
  parameter int unsigned lat_width_p = 32,
  parameter int unsigned sum_width_p = 48
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   v_i,
  input  logic [lat_width_p-1:0] lat_i,
  output logic [lat_width_p-1:0] min_o,
  output logic [lat_width_p-1:0] max_o,
  output logic [sum_width_p-1:0] sum_o
);

  localparam int unsigned SumExtW = sum_width_p + 1;

  logic [lat_width_p-1:0] r_min, r_max;
  logic [sum_width_p-1:0] r_sum;
  logic [SumExtW-1:0]     w_sum_ext;
  logic [sum_width_p-1:0] w_sum_sat;

  // One spare bit catches the carry so the sum clamps instead of wrapping
  assign w_sum_ext = {1'b0, r_sum} + SumExtW'(lat_i);
  assign w_sum_sat = w_sum_ext[sum_width_p] ? '1 : w_sum_ext[sum_width_p-1:0];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_min <= '1;
      r_max <= '0;
      r_sum <= '0;
    end else if (v_i) begin
      if (lat_i < r_min) r_min <= lat_i;
      if (lat_i > r_max) r_max <= lat_i;
      r_sum <= w_sum_sat;
    end
  end

  assign min_o = r_min;
  assign max_o = r_max;
  assign sum_o = r_sum;

endmodule

// File: rtl/bp_me_nonsynth_lce_req_stats.sv
// LCE request latency/statistics monitor; observes request handshakes and completions only.
// Optional watchdog (timeout_o) is built when BP_ME_NONSYNTH_LCE_STATS_WATCHDOG_EN is defined.
module bp_me_nonsynth_lce_req_stats
  import bp_me_nonsynth_pkg::*;
#(
  parameter int unsigned paddr_width_p  = 40,
  parameter int unsigned lce_id_width_p = 4,
  parameter int unsigned cce_id_width_p = 4,
  parameter int unsigned lce_assoc_p    = 8,
  parameter int unsigned lat_width_p    = 32,
  parameter int unsigned sum_width_p    = 48,
  parameter int unsigned count_width_p  = 32,
  parameter int unsigned timeout_p      = 4096,
  localparam int unsigned lce_req_header_width_lp =
    lce_req_header_width(paddr_width_p, lce_id_width_p, cce_id_width_p, lce_assoc_p)
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [lce_req_header_width_lp-1:0] lce_req_header_i,
  input  logic                               lce_req_header_v_i,
  input  logic                               lce_req_header_ready_and_i,
  input  logic                               cache_req_complete_i,
  input  logic                               uc_store_req_complete_i,
  output logic                               busy_o,
  output logic [count_width_p-1:0]           req_count_o,
  output logic [count_width_p-1:0]           uc_count_o,
  output logic [lat_width_p-1:0]             lat_min_o,
  output logic [lat_width_p-1:0]             lat_max_o,
  output logic [sum_width_p-1:0]             lat_sum_o,
  output logic                               overlap_err_o,
  output logic                               spurious_err_o
`ifdef BP_ME_NONSYNTH_LCE_STATS_WATCHDOG_EN
  ,
  output logic                               timeout_o
`endif
);

  bp_me_lce_stats_state_e r_state, w_state_n;
  logic [lat_width_p-1:0]   r_lat, w_lat_n, w_lat_inc;
  logic                     r_uc, w_uc_n;
  logic [count_width_p-1:0] r_req_count, r_uc_count;
  logic                     r_overlap, r_spurious;
  logic                     w_hs, w_done, w_rec, w_overlap, w_spurious, w_hdr_uc;
  logic                     w_unused_hdr;

  assign w_hs     = lce_req_header_v_i & lce_req_header_ready_and_i;
  assign w_done   = cache_req_complete_i | uc_store_req_complete_i;
  assign w_hdr_uc = is_uc_req(lce_req_header_i[MsgTypeWidth-1:0]);
  assign w_unused_hdr = ^lce_req_header_i;

  // Saturating increment; also the latency L recorded on completion
  assign w_lat_inc = (&r_lat) ? r_lat : r_lat + lat_width_p'(1);

  always_comb begin
    w_state_n  = r_state;
    w_lat_n    = r_lat;
    w_uc_n     = r_uc;
    w_rec      = 1'b0;
    w_overlap  = 1'b0;
    w_spurious = 1'b0;
    unique case (r_state)
      e_stats_idle: begin
        if (w_done) w_spurious = 1'b1;
        if (w_hs) begin
          w_state_n = e_stats_wait;
          w_lat_n   = '0;
          w_uc_n    = w_hdr_uc;
        end
      end
      e_stats_wait: begin
        w_lat_n = w_lat_inc;
        if (w_done) begin
          w_rec = 1'b1;
          if (!w_hs) w_state_n = e_stats_idle;
        end else if (w_hs) begin
          w_overlap = 1'b1;
        end
        if (w_hs) begin
          w_lat_n = '0;
          w_uc_n  = w_hdr_uc;
        end
      end
      default: w_state_n = e_stats_idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= e_stats_idle;
      r_lat       <= '0;
      r_uc        <= 1'b0;
      r_req_count <= '0;
      r_uc_count  <= '0;
      r_overlap   <= 1'b0;
      r_spurious  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_lat   <= w_lat_n;
      r_uc    <= w_uc_n;
      if (w_rec) begin
        r_req_count <= r_req_count + count_width_p'(1);
        if (r_uc) r_uc_count <= r_uc_count + count_width_p'(1);
      end
      if (w_overlap)  r_overlap  <= 1'b1;
      if (w_spurious) r_spurious <= 1'b1;
    end
  end

  bp_me_nonsynth_lat_accum #(
    .lat_width_p (lat_width_p),
    .sum_width_p (sum_width_p)
  ) u_accum (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (w_rec),
    .lat_i   (w_lat_inc),
    .min_o   (lat_min_o),
    .max_o   (lat_max_o),
    .sum_o   (lat_sum_o)
  );

`ifdef BP_ME_NONSYNTH_LCE_STATS_WATCHDOG_EN
  localparam int unsigned CmpW = lat_width_p + 32;

  logic [paddr_width_p-1:0] r_addr;
  logic                     r_timeout;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_addr    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_hs) r_addr <= lce_req_header_i[AddrLsb +: paddr_width_p];
      if ((r_state == e_stats_wait) && !w_done && !r_timeout
          && (CmpW'(r_lat) >= CmpW'(timeout_p - 1))) begin
        r_timeout <= 1'b1;
        $error("%0t: LCE request watchdog expired, addr %h", $time, r_addr);
      end
    end
  end

  assign timeout_o = r_timeout;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (timeout_p == 0);
`endif

  assign busy_o         = (r_state == e_stats_wait);
  assign req_count_o    = r_req_count;
  assign uc_count_o     = r_uc_count;
  assign overlap_err_o  = r_overlap;
  assign spurious_err_o = r_spurious;

endmodule

// File: tb/tb_bp_me_nonsynth_lce_req_stats.sv
// Directed bench for bp_me_nonsynth_lce_req_stats with lat_width_p=4 so saturation is reachable.
module tb_bp_me_nonsynth_lce_req_stats;
  import bp_me_nonsynth_pkg::*;

  localparam int unsigned HdrW = lce_req_header_width(40, 4, 4, 8);
  localparam int unsigned LatW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [HdrW-1:0] hdr;
  logic            hdr_v, hdr_rdy, cache_done, uc_done;
  logic            busy, overlap_err, spurious_err;
  logic [31:0]     req_count, uc_count;
  logic [LatW-1:0] lat_min, lat_max;
  logic [47:0]     lat_sum;
`ifdef BP_ME_NONSYNTH_LCE_STATS_WATCHDOG_EN
  logic            timeout;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bp_me_nonsynth_lce_req_stats #(
    .lat_width_p (LatW)
  ) dut (
    .clk_i                      (clk),
    .reset_i                    (reset),
    .lce_req_header_i           (hdr),
    .lce_req_header_v_i         (hdr_v),
    .lce_req_header_ready_and_i (hdr_rdy),
    .cache_req_complete_i       (cache_done),
    .uc_store_req_complete_i    (uc_done),
    .busy_o                     (busy),
    .req_count_o                (req_count),
    .uc_count_o                 (uc_count),
    .lat_min_o                  (lat_min),
    .lat_max_o                  (lat_max),
    .lat_sum_o                  (lat_sum),
    .overlap_err_o              (overlap_err),
    .spurious_err_o             (spurious_err)
`ifdef BP_ME_NONSYNTH_LCE_STATS_WATCHDOG_EN
    ,
    .timeout_o                  (timeout)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic drive(input logic hs, input logic [3:0] msg, input logic cd, input logic ud);
    hdr           = '0;
    hdr[3:0]      = msg;
    hdr[8 +: 40]  = 40'h12_3456_7890;
    hdr_v         = hs;
    hdr_rdy       = hs;
    cache_done    = cd;
    uc_done       = ud;
    step();
    hdr_v      = 1'b0;
    hdr_rdy    = 1'b0;
    cache_done = 1'b0;
    uc_done    = 1'b0;
  endtask

  task automatic check_stats(input string tag, input int cnt, input int ucc, input int mn,
                             input int mx, input int sm);
    chk({tag, ".count"}, 64'(req_count), 64'(cnt));
    chk({tag, ".uc"},    64'(uc_count),  64'(ucc));
    chk({tag, ".min"},   64'(lat_min),   64'(mn));
    chk({tag, ".max"},   64'(lat_max),   64'(mx));
    chk({tag, ".sum"},   64'(lat_sum),   64'(sm));
  endtask

  initial begin
    hdr = '0; hdr_v = 0; hdr_rdy = 0; cache_done = 0; uc_done = 0; reset = 0;
    do_reset();

    // Reset state
    chk("rst.busy", 64'(busy), 0);
    check_stats("rst", 0, 0, 15, 0, 0);
    chk("rst.ovl", 64'(overlap_err), 0);
    chk("rst.spur", 64'(spurious_err), 0);

    // Cached read, L=5
    drive(1, e_bedrock_req_rd, 0, 0);
    chk("c5.busy_start", 64'(busy), 1);
    step(4);
    chk("c5.busy_mid", 64'(busy), 1);
    drive(0, 0, 1, 0);
    chk("c5.busy_end", 64'(busy), 0);
    check_stats("c5", 1, 0, 5, 5, 5);

    // uc_wr with L=1, then cached read with L=7
    do_reset();
    drive(1, e_bedrock_req_uc_wr, 0, 0);
    drive(0, 0, 0, 1);
    drive(1, e_bedrock_req_rd, 0, 0);
    step(6);
    drive(0, 0, 1, 0);
    check_stats("uc17", 2, 1, 1, 7, 8);

    // Spurious completion while idle: sticky, stats untouched
    drive(0, 0, 1, 0);
    chk("spur.set", 64'(spurious_err), 1);
    step(3);
    chk("spur.sticky", 64'(spurious_err), 1);
    chk("spur.busy", 64'(busy), 0);
    check_stats("spur", 2, 1, 1, 7, 8);

    // Overlap: hs@0, hs@3, done@8 -> only second request recorded, L=5
    do_reset();
    drive(1, e_bedrock_req_rd, 0, 0);
    step(2);
    drive(1, e_bedrock_req_uc_rd, 0, 0);
    step(4);
    drive(0, 0, 1, 0);
    chk("ovl.err", 64'(overlap_err), 1);
    chk("ovl.spur", 64'(spurious_err), 0);
    check_stats("ovl", 1, 1, 5, 5, 5);

    // Back-to-back: done+hs together (L=3), second request L=4
    do_reset();
    drive(1, e_bedrock_req_uc_rd, 0, 0);
    step(2);
    drive(1, e_bedrock_req_rd, 1, 0);
    chk("b2b.busy", 64'(busy), 1);
    step(3);
    drive(0, 0, 1, 0);
    check_stats("b2b", 2, 1, 3, 4, 7);
    chk("b2b.ovl", 64'(overlap_err), 0);
    chk("b2b.spur", 64'(spurious_err), 0);

    // Valid without ready is no handshake; hs+done while idle is spurious then starts
    do_reset();
    hdr_v = 1'b1;
    step();
    hdr_v = 1'b0;
    chk("nordy.busy", 64'(busy), 0);
    drive(1, e_bedrock_req_rd, 1, 0);
    chk("idlehs.spur", 64'(spurious_err), 1);
    chk("idlehs.busy", 64'(busy), 1);
    chk("idlehs.count", 64'(req_count), 0);
    drive(0, 0, 0, 1);
    check_stats("idlehs", 1, 0, 1, 1, 1);

    // 20 cycles outstanding with a 4-bit counter saturates at 15
    do_reset();
    drive(1, e_bedrock_req_wr, 0, 0);
    step(19);
    drive(0, 0, 1, 0);
    check_stats("sat", 1, 0, 15, 15, 15);
`ifdef BP_ME_NONSYNTH_LCE_STATS_WATCHDOG_EN
    chk("sat.timeout", 64'(timeout), 0);
`endif

    // Reset mid-request abandons it
    drive(1, e_bedrock_req_rd, 0, 0);
    step(3);
    do_reset();
    chk("abandon.busy", 64'(busy), 0);
    check_stats("abandon", 0, 0, 15, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
